// File: rtl/rr_arb_pkg.sv
// Shared types and constants for the round-robin 2:1 mux front end.
package rr_arb_pkg;

   // Output register occupancy
   typedef enum logic {
      EMPTY = 1'b0,
      FULL  = 1'b1
   } rr_state_e;

   // Channel encoding; matches the mux select (1 picks A)
   localparam logic CH_A = 1'b1;
   localparam logic CH_B = 1'b0;

endpackage

// File: rtl/mux2to1_w.sv
// Parameterised WIDTH-bit 2:1 mux: f = s ? a : b.
module mux2to1_w #(
   parameter int WIDTH = 8
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             s,
   output logic [WIDTH-1:0] f
);

   // Pure select, no state
   always_comb begin
      f = s ? a : b;
   end

endmodule

// File: rtl/rr_arb2_mux.sv
// rr_arb2_mux: round-robin arbiter between two valid/ready sources feeding a
// registered 2:1 mux stage with a valid/ready output.
//
// Handshake: a word moves across an interface on a rising clk edge where
// valid and ready are both high; valid never waits on ready, ready depends
// only on the valids, f_ready and the occupancy state (never on data).
//
// Optional feature macro RR_GRANT_CNT_EN adds saturating per-channel
// transfer counters cnt_a / cnt_b (CNT_W bits each).
module rr_arb2_mux
   import rr_arb_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] a_data,
   input  logic             a_valid,
   output logic             a_ready,
   input  logic [WIDTH-1:0] b_data,
   input  logic             b_valid,
   output logic             b_ready,
   output logic [WIDTH-1:0] f_data,
   output logic             f_valid,
   input  logic             f_ready,
   output logic             f_src,
`ifdef RR_GRANT_CNT_EN
   output logic [CNT_W-1:0] cnt_a,
   output logic [CNT_W-1:0] cnt_b,
`endif
   output logic             dbg_state
);

   rr_state_e        state_q, state_d;
   logic [WIDTH-1:0] f_data_q, f_data_d;
   logic             f_src_q, f_src_d;
   logic             last_grant_q, last_grant_d;

   logic             grant_a, grant_b;
   logic             can_load;
   logic             load;
   logic [WIDTH-1:0] mux_f;

   // Grant: a lone requester wins; on contention the channel not granted last wins
   always_comb begin
      grant_a  = a_valid & (~b_valid | (last_grant_q == CH_B));
      grant_b  = b_valid & (~a_valid | (last_grant_q == CH_A));
      can_load = (state_q == EMPTY) | f_ready;
      a_ready  = grant_a & can_load;
      b_ready  = grant_b & can_load;
      load     = (a_valid & a_ready) | (b_valid & b_ready);
   end

   mux2to1_w #(.WIDTH(WIDTH)) u_mux (
      .a (a_data),
      .b (b_data),
      .s (grant_a),
      .f (mux_f)
   );

   // Next state: load wins over drain, so a full register refills without a bubble
   always_comb begin
      state_d      = state_q;
      f_data_d     = f_data_q;
      f_src_d      = f_src_q;
      last_grant_d = last_grant_q;
      if (load) begin
         f_data_d     = mux_f;
         f_src_d      = grant_a;
         last_grant_d = grant_a ? CH_A : CH_B;
         state_d      = FULL;
      end else if ((state_q == FULL) && f_ready) begin
         state_d = EMPTY;
      end
   end

   // Output register and priority pointer
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= EMPTY;
         f_data_q     <= '0;
         f_src_q      <= 1'b0;
         last_grant_q <= CH_B;
      end else begin
         state_q      <= state_d;
         f_data_q     <= f_data_d;
         f_src_q      <= f_src_d;
         last_grant_q <= last_grant_d;
      end
   end

   assign f_data    = f_data_q;
   assign f_src     = f_src_q;
   assign f_valid   = (state_q == FULL);
   assign dbg_state = state_q;

`ifdef RR_GRANT_CNT_EN
   logic [CNT_W-1:0] cnt_a_q, cnt_a_d;
   logic [CNT_W-1:0] cnt_b_q, cnt_b_d;

   // Count accepted transfers per channel, holding at all-ones
   always_comb begin
      cnt_a_d = cnt_a_q;
      cnt_b_d = cnt_b_q;
      if (a_valid && a_ready && (cnt_a_q != {CNT_W{1'b1}})) cnt_a_d = cnt_a_q + 1'b1;
      if (b_valid && b_ready && (cnt_b_q != {CNT_W{1'b1}})) cnt_b_d = cnt_b_q + 1'b1;
   end

   // Counter registers
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_a_q <= '0;
         cnt_b_q <= '0;
      end else begin
         cnt_a_q <= cnt_a_d;
         cnt_b_q <= cnt_b_d;
      end
   end

   assign cnt_a = cnt_a_q;
   assign cnt_b = cnt_b_q;
`endif

endmodule

// File: tb/tb_rr_arb2_mux.sv
// Directed testbench for rr_arb2_mux. Inputs change on the falling edge,
// outputs are sampled on the falling edge (or #1 after it for readies).
module tb_rr_arb2_mux;

   localparam int WIDTH = 8;
`ifdef RR_GRANT_CNT_EN
   localparam int CNT_W = 2;
`else
   localparam int CNT_W = 16;
`endif

   logic             clk = 1'b0;
   logic             rst;
   logic [WIDTH-1:0] a_data, b_data;
   logic             a_valid, b_valid, a_ready, b_ready;
   logic [WIDTH-1:0] f_data;
   logic             f_valid, f_ready, f_src;
   logic             dbg_state;
`ifdef RR_GRANT_CNT_EN
   logic [CNT_W-1:0] cnt_a, cnt_b;
`endif

   int checks   = 0;
   int failures = 0;

   // Clock / reset block
   always #5 clk = ~clk;

   rr_arb2_mux #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .a_data    (a_data),
      .a_valid   (a_valid),
      .a_ready   (a_ready),
      .b_data    (b_data),
      .b_valid   (b_valid),
      .b_ready   (b_ready),
      .f_data    (f_data),
      .f_valid   (f_valid),
      .f_ready   (f_ready),
      .f_src     (f_src),
`ifdef RR_GRANT_CNT_EN
      .cnt_a     (cnt_a),
      .cnt_b     (cnt_b),
`endif
      .dbg_state (dbg_state)
   );

   // Producer-rule monitor: a pending word must stay valid and stable
   logic             pend_a = 1'b0, pend_b = 1'b0;
   logic [WIDTH-1:0] pend_a_data, pend_b_data;
   always @(posedge clk) begin
      if (!rst) begin
         if (pend_a) begin
            checks++;
            if (!(a_valid === 1'b1 && a_data === pend_a_data)) begin
               failures++;
               $display("FAIL producer_a: valid=%b data=%h required valid=1 data=%h", a_valid, a_data, pend_a_data);
            end
         end
         if (pend_b) begin
            checks++;
            if (!(b_valid === 1'b1 && b_data === pend_b_data)) begin
               failures++;
               $display("FAIL producer_b: valid=%b data=%h required valid=1 data=%h", b_valid, b_data, pend_b_data);
            end
         end
      end
      pend_a      = !rst && a_valid && !a_ready;
      pend_b      = !rst && b_valid && !b_ready;
      pend_a_data = a_data;
      pend_b_data = b_data;
   end

   // Driver tasks
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0; f_ready = 1'b0;
      a_data = '0; b_data = '0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if (f_valid !== 1'b0 || f_data !== 8'h00 || f_src !== 1'b0 || dbg_state !== 1'b0) begin
         failures++;
         $display("FAIL reset_state: f_valid=%b f_data=%h f_src=%b state=%b required 0 00 0 0",
                  f_valid, f_data, f_src, dbg_state);
      end
      #1;
      checks++;
      if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
         failures++;
         $display("FAIL reset_ready: a_ready=%b b_ready=%b required 0 0", a_ready, b_ready);
      end
   endtask

   task automatic test_single_a();
      a_valid = 1'b1; a_data = 8'h11; f_ready = 1'b1;
      #1;
      checks++;
      if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
         failures++;
         $display("FAIL single_a_ready: a_ready=%b b_ready=%b required 1 0", a_ready, b_ready);
      end
      @(negedge clk);
      a_valid = 1'b0;
      checks++;
      if (f_valid !== 1'b1 || f_data !== 8'h11 || f_src !== 1'b1) begin
         failures++;
         $display("FAIL single_a_out: f_valid=%b f_data=%h f_src=%b required 1 11 1", f_valid, f_data, f_src);
      end
      @(negedge clk);
      checks++;
      if (f_valid !== 1'b0) begin
         failures++;
         $display("FAIL single_a_drain: f_valid=%b required 0", f_valid);
      end
   endtask

   task automatic test_round_robin();
      logic [WIDTH-1:0] exp_d;
      do_reset();
      a_valid = 1'b1; a_data = 8'hAA; b_valid = 1'b1; b_data = 8'hBB; f_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         exp_d = (i % 2 == 0) ? 8'hAA : 8'hBB;
         checks++;
         if (f_valid !== 1'b1 || f_data !== exp_d || f_src !== (i % 2 == 0)) begin
            failures++;
            $display("FAIL rr_out[%0d]: f_valid=%b f_data=%h f_src=%b required 1 %h %b",
                     i, f_valid, f_data, f_src, exp_d, (i % 2 == 0));
         end
         #1;
         checks++;
         if (a_ready !== (i % 2 == 1) || b_ready !== (i % 2 == 0)) begin
            failures++;
            $display("FAIL rr_ready[%0d]: a_ready=%b b_ready=%b required %b %b",
                     i, a_ready, b_ready, (i % 2 == 1), (i % 2 == 0));
         end
      end
   endtask

   task automatic test_back_pressure();
      do_reset();
      a_valid = 1'b1; a_data = 8'hAA; b_valid = 1'b1; b_data = 8'hBB; f_ready = 1'b1;
      @(negedge clk);
      f_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if (a_ready !== 1'b0 || b_ready !== 1'b0 || f_valid !== 1'b1 || f_data !== 8'hAA || f_src !== 1'b1) begin
            failures++;
            $display("FAIL bp_hold[%0d]: a_ready=%b b_ready=%b f_valid=%b f_data=%h f_src=%b required 0 0 1 aa 1",
                     i, a_ready, b_ready, f_valid, f_data, f_src);
         end
         @(negedge clk);
      end
      f_ready = 1'b1;
      #1;
      checks++;
      if (a_ready !== 1'b0 || b_ready !== 1'b1) begin
         failures++;
         $display("FAIL bp_release: a_ready=%b b_ready=%b required 0 1", a_ready, b_ready);
      end
      @(negedge clk);
      checks++;
      if (f_valid !== 1'b1 || f_data !== 8'hBB || f_src !== 1'b0) begin
         failures++;
         $display("FAIL bp_next: f_valid=%b f_data=%h f_src=%b required 1 bb 0", f_valid, f_data, f_src);
      end
   endtask

   task automatic test_only_b();
      logic [WIDTH-1:0] exp_d;
      do_reset();
      f_ready = 1'b1; b_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         exp_d  = 8'hB0 + 8'(i);
         b_data = exp_d;
         @(negedge clk);
         checks++;
         if (f_data !== exp_d || f_src !== 1'b0 || f_valid !== 1'b1) begin
            failures++;
            $display("FAIL only_b[%0d]: f_data=%h f_src=%b f_valid=%b required %h 0 1",
                     i, f_data, f_src, f_valid, exp_d);
         end
      end
      a_valid = 1'b1; a_data = 8'hA1; b_data = 8'hB4;
      #1;
      checks++;
      if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
         failures++;
         $display("FAIL only_b_then_a: a_ready=%b b_ready=%b required 1 0", a_ready, b_ready);
      end
      @(negedge clk);
      checks++;
      if (f_data !== 8'hA1 || f_src !== 1'b1) begin
         failures++;
         $display("FAIL only_b_a_out: f_data=%h f_src=%b required a1 1", f_data, f_src);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      a_valid = 1'b1; a_data = 8'h5A; f_ready = 1'b0;
      @(negedge clk);
      a_valid = 1'b0;
      checks++;
      if (f_valid !== 1'b1 || f_data !== 8'h5A || dbg_state !== 1'b1) begin
         failures++;
         $display("FAIL mid_full: f_valid=%b f_data=%h state=%b required 1 5a 1", f_valid, f_data, dbg_state);
      end
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      checks++;
      if (f_valid !== 1'b0 || f_data !== 8'h00 || f_src !== 1'b0) begin
         failures++;
         $display("FAIL mid_reset: f_valid=%b f_data=%h f_src=%b required 0 00 0", f_valid, f_data, f_src);
      end
      a_valid = 1'b1; a_data = 8'hC1; b_valid = 1'b1; b_data = 8'hC2; f_ready = 1'b1;
      #1;
      checks++;
      if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
         failures++;
         $display("FAIL mid_prio: a_ready=%b b_ready=%b required 1 0", a_ready, b_ready);
      end
      @(negedge clk);
      checks++;
      if (f_data !== 8'hC1 || f_src !== 1'b1) begin
         failures++;
         $display("FAIL mid_first: f_data=%h f_src=%b required c1 1", f_data, f_src);
      end
   endtask

`ifdef RR_GRANT_CNT_EN
   task automatic test_grant_cnt();
      do_reset();
      checks++;
      if (cnt_a !== 2'd0 || cnt_b !== 2'd0) begin
         failures++;
         $display("FAIL cnt_reset: cnt_a=%0d cnt_b=%0d required 0 0", cnt_a, cnt_b);
      end
      a_valid = 1'b1; a_data = 8'h33; f_ready = 1'b1;
      repeat (5) @(negedge clk);
      a_valid = 1'b0;
      checks++;
      if (cnt_a !== 2'd3 || cnt_b !== 2'd0) begin
         failures++;
         $display("FAIL cnt_sat: cnt_a=%0d cnt_b=%0d required 3 0", cnt_a, cnt_b);
      end
      b_valid = 1'b1; b_data = 8'h44;
      @(negedge clk);
      b_valid = 1'b0;
      checks++;
      if (cnt_a !== 2'd3 || cnt_b !== 2'd1) begin
         failures++;
         $display("FAIL cnt_b: cnt_a=%0d cnt_b=%0d required 3 1", cnt_a, cnt_b);
      end
   endtask
`endif

   initial begin
      rst = 1'b1; a_valid = 1'b0; b_valid = 1'b0; f_ready = 1'b0;
      a_data = '0; b_data = '0;
      test_reset();
      test_single_a();
      test_round_robin();
      test_back_pressure();
      test_only_b();
      test_reset_mid();
`ifdef RR_GRANT_CNT_EN
      test_grant_cnt();
`endif
      do_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
